// File: rtl/bankgroup_pkg.sv
// bankgroup_pkg: command bit indices and FSM state encoding shared by the scheduler
// REF states exist only when BANKGROUP_SCHEDULER_REFRESH_EN is defined
package bankgroup_pkg;
  localparam int CMD_W = 19;
  localparam int CMD_ACT = 0;
  localparam int CMD_PRE = 1;
  localparam int CMD_RD = 2;
  localparam int CMD_WR = 3;
  localparam int CMD_REF = 4;
  typedef enum logic [3:0] {
    IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RDWR, WAIT_CCD
`ifdef BANKGROUP_SCHEDULER_REFRESH_EN
    , REF_PRE, REF, WAIT_RFC
`endif
  } state_t;
  function automatic logic [CMD_W-1:0] cmd_bit(input int idx);
    return CMD_W'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer holds the last granted requester
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last;
  always_comb grant = &valid ? (last ? 2'b01 : 2'b10) : valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (accept) last <= grant[1];
endmodule

// File: rtl/bankgroup_scheduler.sv
// bankgroup_scheduler: two-requester bank-group command scheduler (ACT/PRE/RD/WR, optional REF)
// Define BANKGROUP_SCHEDULER_REFRESH_EN to build the periodic refresh engine.
module bankgroup_scheduler
  import bankgroup_pkg::*;
#(
  parameter int ADDRWIDTH = 17,
  parameter int BANKSPERGROUP = 2,
  parameter int COLS = 1024,
  parameter int TRCD = 4,
  parameter int TRP = 4,
  parameter int TCCD = 4,
  parameter int TREFI = 64,
  parameter int TRFC = 8,
  localparam int BAWIDTH = (BANKSPERGROUP > 1) ? $clog2(BANKSPERGROUP) : 1,
  localparam int CADDRWIDTH = $clog2(COLS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][BAWIDTH-1:0]    req_ba,
  input  logic [1:0][ADDRWIDTH-1:0]  req_row,
  input  logic [1:0][CADDRWIDTH-1:0] req_col,
  input  logic [1:0]                 req_we,
  output logic [CMD_W-1:0]           cmd,
  output logic [BAWIDTH-1:0]         ba,
  output logic [ADDRWIDTH-1:0]       row,
  output logic [CADDRWIDTH-1:0]      column,
  output logic                       done,
  output logic                       done_id
);
  localparam int CW = 16;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BANKSPERGROUP-1:0] open_q, open_n;
  logic [ADDRWIDTH-1:0] open_row [BANKSPERGROUP];
  logic [BAWIDTH-1:0] l_ba, ba_n;
  logic [ADDRWIDTH-1:0] l_row, row_n;
  logic [CADDRWIDTH-1:0] l_col, col_n;
  logic [CMD_W-1:0] cmd_n;
  logic l_we, l_id, done_n, row_wr, accept, id, ref_pend;
  logic [1:0] grant;
  // a wait state covering t-1 cycles is entered with t-2 and exits on zero
  function automatic logic [CW-1:0] wait_cnt(input int t);
    return CW'(t > 1 ? t - 2 : 0);
  endfunction
  rr_arbiter2 u_arb (.clk(clk), .reset(reset), .valid(req_valid), .accept(accept), .grant(grant));
  always_comb req_ready = (!reset && state == IDLE && !ref_pend) ? grant : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign id = req_ready[1];
`ifdef BANKGROUP_SCHEDULER_REFRESH_EN
  logic [CW-1:0] ref_cnt;
  logic [BAWIDTH-1:0] lo;
  logic ref_clr;
  always_comb begin
    lo = '0;
    for (int i = BANKSPERGROUP - 1; i >= 0; i--) if (open_q[i]) lo = BAWIDTH'(i);
  end
  // a new tick wins over the clear so a refresh is never lost
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ref_cnt <= '0;
      ref_pend <= 1'b0;
    end else begin
      ref_cnt <= (ref_cnt == CW'(TREFI - 1)) ? '0 : ref_cnt + CW'(1);
      ref_pend <= (ref_cnt == CW'(TREFI - 1)) | (ref_pend & ~ref_clr);
    end
`else
  assign ref_pend = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    open_n = open_q;
    row_wr = 1'b0;
    cmd_n = '0;
    ba_n = '0;
    row_n = '0;
    col_n = '0;
    done_n = 1'b0;
`ifdef BANKGROUP_SCHEDULER_REFRESH_EN
    ref_clr = 1'b0;
`endif
    case (state)
      IDLE:
`ifdef BANKGROUP_SCHEDULER_REFRESH_EN
        if (ref_pend) state_n = |open_q ? REF_PRE : REF;
        else
`endif
        if (accept) state_n = !open_q[req_ba[id]] ? ACT : (open_row[req_ba[id]] == req_row[id]) ? RDWR : PRE;
      PRE: begin
        cmd_n = cmd_bit(CMD_PRE);
        ba_n = l_ba;
        open_n[l_ba] = 1'b0;
        state_n = TRP > 1 ? WAIT_RP : ACT;
        cnt_n = wait_cnt(TRP);
      end
      WAIT_RP: begin
        state_n = cnt == '0 ? ACT : WAIT_RP;
        cnt_n = cnt - CW'(1);
      end
      ACT: begin
        cmd_n = cmd_bit(CMD_ACT);
        ba_n = l_ba;
        row_n = l_row;
        open_n[l_ba] = 1'b1;
        row_wr = 1'b1;
        state_n = TRCD > 1 ? WAIT_RCD : RDWR;
        cnt_n = wait_cnt(TRCD);
      end
      WAIT_RCD: begin
        state_n = cnt == '0 ? RDWR : WAIT_RCD;
        cnt_n = cnt - CW'(1);
      end
      RDWR: begin
        cmd_n = cmd_bit(l_we ? CMD_WR : CMD_RD);
        ba_n = l_ba;
        row_n = l_row;
        col_n = l_col;
        done_n = 1'b1;
        state_n = TCCD > 1 ? WAIT_CCD : IDLE;
        cnt_n = wait_cnt(TCCD);
      end
      WAIT_CCD: begin
        state_n = cnt == '0 ? IDLE : WAIT_CCD;
        cnt_n = cnt - CW'(1);
      end
`ifdef BANKGROUP_SCHEDULER_REFRESH_EN
      REF_PRE:
        if (|open_q) begin
          cmd_n = cmd_bit(CMD_PRE);
          ba_n = lo;
          open_n[lo] = 1'b0;
          cnt_n = wait_cnt(TRP);
          state_n = (open_n == '0 && TRP == 1) ? REF : REF_PRE;
        end else begin
          state_n = cnt == '0 ? REF : REF_PRE;
          cnt_n = cnt - CW'(1);
        end
      REF: begin
        cmd_n = cmd_bit(CMD_REF);
        state_n = TRFC > 1 ? WAIT_RFC : IDLE;
        ref_clr = TRFC == 1;
        cnt_n = wait_cnt(TRFC);
      end
      WAIT_RFC: begin
        state_n = cnt == '0 ? IDLE : WAIT_RFC;
        ref_clr = cnt == '0;
        cnt_n = cnt - CW'(1);
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      open_q <= '0;
      cmd <= '0;
      ba <= '0;
      row <= '0;
      column <= '0;
      done <= 1'b0;
      done_id <= 1'b0;
      l_ba <= '0;
      l_row <= '0;
      l_col <= '0;
      l_we <= 1'b0;
      l_id <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      open_q <= open_n;
      cmd <= cmd_n;
      ba <= ba_n;
      row <= row_n;
      column <= col_n;
      done <= done_n;
      done_id <= done_n & l_id;
      if (accept) begin
        l_ba <= req_ba[id];
        l_row <= req_row[id];
        l_col <= req_col[id];
        l_we <= req_we[id];
        l_id <= id;
      end
    end
  always_ff @(posedge clk)
    if (row_wr) open_row[l_ba] <= l_row;
endmodule
